// File: rtl/int_calc_pkg.sv
// Shared opcodes, sequencer state encoding and default pipeline latencies for int_calc.
package int_calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 36;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/int_res_sel.sv
// Combinational result/flag select for one completed int_calc operation.
// Zero latency; no flow control of its own.
module int_res_sel
  import int_calc_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic        fault_i,
  input  logic [31:0] calc_a_lo_i,
  input  logic [31:0] int_add_i,
  input  logic [31:0] int_sub_i,
  input  logic [63:0] int_mul_i,
  input  logic [31:0] int_div_i,
  input  logic [31:0] int_mod_i,
  input  logic        add_co_i,
  input  logic        add_cy_i,
  input  logic        sub_co_i,
  input  logic        sub_cy_i,
  output logic [63:0] result_o,
  output logic        co_o,
  output logic        cy_o,
  output logic        err_o
);

  always_comb begin
    result_o = '0;
    co_o     = 1'b0;
    cy_o     = 1'b0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = {32'b0, int_add_i};
        co_o     = add_co_i;
        cy_o     = add_cy_i;
      end
      OP_SUB: begin
        result_o = {32'b0, int_sub_i};
        co_o     = sub_co_i;
        cy_o     = sub_cy_i;
      end
      OP_MUL: result_o = int_mul_i;
      OP_DIV: begin
        // Saturated quotient when it cannot fit in 32 bits (incl. divide by zero)
        result_o = fault_i ? 64'h0000_0000_FFFF_FFFF : {32'b0, int_div_i};
        err_o    = fault_i;
      end
      OP_MOD: begin
        result_o = fault_i ? {32'b0, calc_a_lo_i} : {32'b0, int_mod_i};
        err_o    = fault_i;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/int_calc_seq.sv
// Issue/collect sequencer for int_calc: one op in flight, result after the unit's LAT edges.
// in_ready only in IDLE; result held with out_valid until out_ready.
module int_calc_seq
  import int_calc_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [63:0] a,
  input  logic [31:0] b,
  output logic [63:0] calc_A,
  output logic [31:0] calc_B,
  input  logic [31:0] int_add,
  input  logic [31:0] int_sub,
  input  logic [63:0] int_mul,
  input  logic [31:0] int_div,
  input  logic [31:0] int_mod,
  input  logic        addCo,
  input  logic        addCy,
  input  logic        subCo,
  input  logic        subCy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        co,
  output logic        cy,
  output logic        err
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               fault_q, fault_d;
  logic [63:0]        calc_a_q, calc_a_d;
  logic [31:0]        calc_b_q, calc_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        result_q, result_d;
  logic               co_q, co_d, cy_q, cy_d, err_q, err_d;
  logic               out_valid_q, out_valid_d;

  logic               is_div, fault_now;
  logic [CNT_W-1:0]   lat_m1;
  logic [63:0]        sel_result;
  logic               sel_co, sel_cy, sel_err;

  // Fault is decided from the raw inputs so a faulted divide skips the long wait
  assign is_div    = (op == OP_DIV) || (op == OP_MOD);
  assign fault_now = is_div && (a[63:32] >= b);

  always_comb begin
    lat_m1 = '0;
    if (op == OP_MUL)
      lat_m1 = MUL_M1;
    else if (is_div && !fault_now)
      lat_m1 = DIV_M1;
  end

  int_res_sel u_res_sel (
    .op_i        (op_q),
    .fault_i     (fault_q),
    .calc_a_lo_i (calc_a_q[31:0]),
    .int_add_i   (int_add),
    .int_sub_i   (int_sub),
    .int_mul_i   (int_mul),
    .int_div_i   (int_div),
    .int_mod_i   (int_mod),
    .add_co_i    (addCo),
    .add_cy_i    (addCy),
    .sub_co_i    (subCo),
    .sub_cy_i    (subCy),
    .result_o    (sel_result),
    .co_o        (sel_co),
    .cy_o        (sel_cy),
    .err_o       (sel_err)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fault_d     = fault_q;
    calc_a_d    = calc_a_q;
    calc_b_d    = calc_b_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    co_d        = co_q;
    cy_d        = cy_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d     = op;
          fault_d  = fault_now;
          calc_a_d = a;
          calc_b_d = b;
          cnt_d    = lat_m1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d    = sel_result;
          co_d        = sel_co;
          cy_d        = sel_cy;
          err_d       = sel_err;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      fault_q     <= 1'b0;
      calc_a_q    <= '0;
      calc_b_q    <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      co_q        <= 1'b0;
      cy_q        <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      fault_q     <= fault_d;
      calc_a_q    <= calc_a_d;
      calc_b_q    <= calc_b_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      co_q        <= co_d;
      cy_q        <= cy_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign calc_A    = calc_a_q;
  assign calc_B    = calc_b_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign co        = co_q;
  assign cy        = cy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_int_calc_seq.sv
// Directed bench for int_calc_seq with a latency-accurate stand-in for int_calc.
module tb_int_calc_seq;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 36;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [63:0] a, calc_A, int_mul, result;
  logic [31:0] b, calc_B, int_add, int_sub, int_div, int_mod;
  logic        addCo, addCy, subCo, subCy, co, cy, err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  int_calc_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .calc_A(calc_A), .calc_B(calc_B),
    .int_add(int_add), .int_sub(int_sub), .int_mul(int_mul),
    .int_div(int_div), .int_mod(int_mod),
    .addCo(addCo), .addCy(addCy), .subCo(subCo), .subCy(subCy),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .co(co), .cy(cy), .err(err)
  );

  // int_calc stand-in: add/sub combinational, mul/div valid LAT edges after operands change
  logic [32:0] add_w, sub_w;
  assign add_w   = {1'b0, calc_A[31:0]} + {1'b0, calc_B};
  assign sub_w   = {1'b0, calc_A[31:0]} - {1'b0, calc_B};
  assign int_add = add_w[31:0];
  assign addCy   = add_w[32];
  assign addCo   = (calc_A[31] == calc_B[31]) && (add_w[31] != calc_A[31]);
  assign int_sub = sub_w[31:0];
  assign subCy   = sub_w[32];
  assign subCo   = (calc_A[31] != calc_B[31]) && (sub_w[31] != calc_A[31]);

  logic [63:0] mul_pipe [MUL_LAT-1];
  logic [31:0] quo_pipe [DIV_LAT-1];
  logic [31:0] rem_pipe [DIV_LAT-1];
  logic [63:0] quo_w, rem_w;
  assign quo_w = (calc_B == 32'd0) ? 64'd0 : calc_A / {32'd0, calc_B};
  assign rem_w = (calc_B == 32'd0) ? 64'd0 : calc_A % {32'd0, calc_B};

  always @(posedge clk) begin
    mul_pipe[0] <= {32'd0, calc_A[31:0]} * {32'd0, calc_B};
    for (int i = 1; i < MUL_LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
    quo_pipe[0] <= quo_w[31:0];
    rem_pipe[0] <= rem_w[31:0];
    for (int j = 1; j < DIV_LAT - 1; j++) begin
      quo_pipe[j] <= quo_pipe[j-1];
      rem_pipe[j] <= rem_pipe[j-1];
    end
  end
  assign int_mul = mul_pipe[MUL_LAT-2];
  assign int_div = quo_pipe[DIV_LAT-2];
  assign int_mod = rem_pipe[DIV_LAT-2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Issue one op from IDLE (called #1 after a rising edge) and wait for out_valid
  task automatic issue(input logic [2:0] o, input logic [63:0] av, input logic [31:0] bv,
                       output int lat);
    in_valid = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] av,
                        input logic [31:0] bv, input int exp_lat, input logic [63:0] exp_res,
                        input logic exp_co, input logic exp_cy, input logic exp_err);
    int lat;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    issue(o, av, bv, lat);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".co_cy_err"}, {61'd0, co, cy, err}, {61'd0, exp_co, exp_cy, exp_err});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drain"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  int lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.outs", {62'd0, out_valid, err}, 64'd0);
    chk("reset.calc_A", calc_A, 64'd0);
    chk("reset.result", result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_wrap", 3'd0, 64'h0000_0000_FFFF_FFFF, 32'd1, 1, 64'd0, 1'b0, 1'b1, 1'b0);
    run_op("add_ovf",  3'd0, 64'h0000_0000_7FFF_FFFF, 32'd1, 1, 64'h8000_0000, 1'b1, 1'b0, 1'b0);
    run_op("mul_max",  3'd2, 64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,
           64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 1'b0);
    run_op("div",      3'd3, 64'd100, 32'd7, DIV_LAT, 64'd14, 1'b0, 1'b0, 1'b0);
    run_op("mod",      3'd4, 64'd100, 32'd7, DIV_LAT, 64'd2, 1'b0, 1'b0, 1'b0);
    run_op("div_wide", 3'd3, 64'h0000_0001_0000_0000, 32'd2, DIV_LAT, 64'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("div_zero", 3'd3, 64'd100, 32'd0, 1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("mod_ovf",  3'd4, 64'h0000_0005_0000_0009, 32'd3, 1, 64'd9, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held, second request ignored and not queued
    issue(3'd2, 64'd3, 32'd4, lat);
    chk("bp.lat", 64'(lat), 64'(MUL_LAT));
    in_valid = 1'b1; op = 3'd0; a = 64'd50; b = 32'd60;
    repeat (10) @(posedge clk);
    #1;
    chk("bp.hold", {61'd0, out_valid, in_ready, err}, 64'b100);
    chk("bp.result", result, 64'd12);
    chk("bp.calc_A", calc_A, 64'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp.no_queue", {62'd0, out_valid, in_ready}, 64'b01);

    // Asynchronous reset mid-divide
    in_valid = 1'b1; op = 3'd3; a = 64'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.calc", {calc_A[31:0], calc_B}, 64'd0);
    chk("rst.result", result, 64'd0);
    chk("rst.flags", {61'd0, out_valid, co, err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.no_done", 64'(out_valid), 64'd0);

    run_op("sub_neg", 3'd1, 64'd5, 32'd7, 1, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b1, 1'b0);
    run_op("illegal", 3'd6, 64'd5, 32'd7, 1, 64'd0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
